seq_det_ctrl: RTL and testbench

//  Controller + datapath for a programmable serial pattern detector (Mealy style, 1001-class).
//  - Accepts a pattern config over a valid/ready handshake and runs a detection session on a qualified bit stream.
//  - Selects overlapping or non-overlapping matching.
//  - Counts matches and ends the session after a programmed match limit.
//  - Sits between the host/config logic and the serial bit source.

---
 rtl/seq_det_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: config handshake, session FSM, match counter.
// Optional bit-count timeout is built only when SEQ_DET_TIMEOUT_EN is defined.
module seq_det_ctrl #(
    parameter int PAT_W   = 4,
    parameter int LEN_W   = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clck,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             det_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] lim_q;
    logic [PAT_W-2:0] hist_q;
    logic [LEN_W-1:0] fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic             det_q;

    logic [LEN_W-1:0] len_norm;
    logic [PAT_W-1:0] hist_nx;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic             acc;
    logic             hit;
    logic             match;
    logic             last_match;
    logic             start_ok;
    logic             tmo_hit;

    // Config handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready;
    // cfg_ready depends only on the state, never on cfg_valid.
    assign cfg_ready = (state_q != ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;
    assign det_pulse = det_q;
    assign match_cnt = cnt_q;

    always_comb begin
        len_norm = cfg_len;
        if (cfg_len < LEN_W'(2)) begin
            len_norm = LEN_W'(2);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            len_norm = LEN_W'(PAT_W);
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        hist_nx    = {hist_q, bit_in};
        fill_nx    = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        hit        = (fill_nx == len_q) && (((hist_nx ^ pat_q) & mask) == '0);
        acc        = (state_q == ST_RUN) && bit_valid && !abort;
        match      = acc && hit;
        cnt_inc    = cnt_q + CNT_W'(1);
        last_match = match && (lim_q != '0) && (cnt_inc == lim_q);
        start_ok   = start && !abort && (state_q != ST_RUN);
    end

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_inc;
    logic          timed_q;

    assign tmo_inc   = tmo_q + TW'(1);
    // A match on the final allowed bit beats the timeout.
    assign tmo_hit   = acc && !hit && (tmo_inc == TW'(TIMEOUT));
    assign timed_out = timed_q;

    always_ff @(posedge clck) begin
        if (!rst_n) begin
            tmo_q   <= '0;
            timed_q <= 1'b0;
        end else if (abort) begin
            timed_q <= 1'b0;
        end else if (start_ok) begin
            tmo_q   <= '0;
            timed_q <= 1'b0;
        end else if (acc) begin
            tmo_q <= hit ? '0 : tmo_inc;
            if (tmo_hit) begin
                timed_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clck) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (abort) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_q <= ST_RUN;
                ST_RUN:  if (last_match || tmo_hit) state_q <= ST_DONE;
                ST_DONE: if (start) state_q <= ST_RUN;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clck) begin
        if (!rst_n) begin
            pat_q <= '0;
            len_q <= LEN_W'(2);
            ovl_q <= 1'b0;
            lim_q <= '0;
        end else if (cfg_valid && cfg_ready) begin
            pat_q <= cfg_pattern;
            len_q <= len_norm;
            ovl_q <= cfg_overlap;
            lim_q <= cfg_limit;
        end
    end

    always_ff @(posedge clck) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            det_q  <= 1'b0;
        end else begin
            det_q <= match;
            if (start_ok) begin
                hist_q <= '0;
                fill_q <= '0;
                cnt_q  <= '0;
            end else if (acc) begin
                hist_q <= hist_nx[PAT_W-2:0];
                // Non-overlapping mode restarts the fill so the next match needs a full new pattern.
                fill_q <= (hit && !ovl_q) ? '0 : fill_nx;
                if (hit && !(&cnt_q)) begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed vector table, hand-written corner sequences,
// then randomized cycles checked against a bit-queue reference model.
module tb_seq_det_ctrl;

    localparam int TMO = 8;

    logic       clck = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_pattern = '0;
    logic [2:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_limit = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       det_pulse;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
    logic       timed_out;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    seq_det_ctrl #(.PAT_W(4), .LEN_W(3), .CNT_W(8), .TIMEOUT(TMO)) dut (
        .clck(clck), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_limit(cfg_limit), .start(start), .abort(abort), .bit_valid(bit_valid),
        .bit_in(bit_in), .det_pulse(det_pulse), .match_cnt(match_cnt), .busy(busy),
        .done(done), .timed_out(timed_out), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clck = ~clck;

    task automatic step();
        @(posedge clck);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic cv, input logic [3:0] pat, input logic [2:0] len,
                         input logic ovl, input logic [7:0] lim, input logic st,
                         input logic ab, input logic bv, input logic bi);
        cfg_valid = cv; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_limit = lim;
        start = st; abort = ab; bit_valid = bv; bit_in = bi;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 4'd0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_cfg(input logic [3:0] pat, input logic [2:0] len, input logic ovl,
                          input logic [7:0] lim);
        drive(1'b1, pat, len, ovl, lim, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_inputs();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1; bit_in = b; step(); bit_valid = 1'b0;
    endtask

    // vector table
    typedef struct {
        logic       cv;
        logic [3:0] pat;
        logic [2:0] len;
        logic       ovl;
        logic [7:0] lim;
        logic       st;
        logic       ab;
        logic       bv;
        logic       bi;
        logic       det;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic st, input logic ab, input logic bv, input logic bi,
                               input logic det, input logic [7:0] cnt, input logic bsy,
                               input logic dn);
        vec_t r;
        r = '{cv: 1'b0, pat: 4'd0, len: 3'd0, ovl: 1'b0, lim: 8'd0, st: st, ab: ab, bv: bv,
              bi: bi, det: det, cnt: cnt, busy: bsy, done: dn};
        return r;
    endfunction

    function automatic vec_t c(input logic [3:0] pat, input logic [2:0] len, input logic ovl,
                               input logic [7:0] lim, input logic [7:0] cnt, input logic dn);
        vec_t r;
        r = '{cv: 1'b1, pat: pat, len: len, ovl: ovl, lim: lim, st: 1'b0, ab: 1'b0, bv: 1'b0,
              bi: 1'b0, det: 1'b0, cnt: cnt, busy: 1'b0, done: dn};
        return r;
    endfunction

    function automatic vec_t b(input logic bi, input logic det, input logic [7:0] cnt);
        return v(1'b0, 1'b0, 1'b1, bi, det, cnt, 1'b1, 1'b0);
    endfunction

    // reference model state
    bit  m_run, m_done, m_timed, m_ovl;
    int  m_cnt, m_tmo, m_pat, m_len, m_lim;
    int  m_q[$];

    task automatic model_reset();
        m_run = 0; m_done = 0; m_timed = 0; m_ovl = 0;
        m_cnt = 0; m_tmo = 0; m_pat = 0; m_len = 2; m_lim = 0;
        m_q.delete();
    endtask

    task automatic model_cycle(input logic cv, input logic [3:0] pat, input logic [2:0] len,
                               input logic ovl, input logic [7:0] lim, input logic st,
                               input logic ab, input logic bv, input logic bi);
        bit run_old;
        bit hit;
        int val;
        int e_det;
        drive(cv, pat, len, ovl, lim, st, ab, bv, bi);
        chk("rnd.cfg_ready", cfg_ready, !m_run);
        step();
        run_old = m_run;
        e_det = 0;
        if (ab) begin
            m_run = 0; m_done = 0; m_timed = 0;
        end else if (st && !m_run) begin
            m_run = 1; m_done = 0; m_timed = 0; m_cnt = 0; m_tmo = 0;
            m_q.delete();
        end else if (m_run && bv) begin
            m_q.push_back(int'(bi));
            if (m_q.size() > 4) void'(m_q.pop_front());
            hit = 0;
            if (m_q.size() >= m_len) begin
                val = 0;
                for (int k = 0; k < m_len; k++) val = val * 2 + m_q[m_q.size() - m_len + k];
                hit = (val == m_pat % (1 << m_len));
            end
            if (hit) begin
                e_det = 1;
                if (m_cnt < 255) m_cnt++;
                if (!m_ovl) m_q.delete();
                m_tmo = 0;
                if (m_lim != 0 && m_cnt == m_lim) begin
                    m_run = 0; m_done = 1;
                end
            end else begin
                m_tmo++;
`ifdef SEQ_DET_TIMEOUT_EN
                if (m_tmo == TMO) begin
                    m_run = 0; m_done = 1; m_timed = 1;
                end
`endif
            end
        end
        if (cv && !run_old) begin
            m_pat = int'(pat);
            m_len = (len < 2) ? 2 : (len > 4) ? 4 : int'(len);
            m_ovl = ovl;
            m_lim = int'(lim);
        end
        chk("rnd.det_pulse", det_pulse, e_det);
        chk("rnd.match_cnt", match_cnt, m_cnt);
        chk("rnd.busy", busy, m_run);
        chk("rnd.done", done, m_done);
        chk("rnd.timed_out", timed_out, m_timed);
    endtask

    initial begin
        logic [3:0] bits_a;
        bits_a = 4'b1001;

        // reset state
        idle_inputs();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk("rst.det_pulse", det_pulse, 0);
        chk("rst.match_cnt", match_cnt, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.timed_out", timed_out, 0);
        chk("rst.cfg_ready", cfg_ready, 1);

        // 1001/len4: overlapping, non-overlapping, limit=2 ending the session
        tbl.push_back(c(4'b1001, 3'd4, 1'b1, 8'd0, 8'd0, 1'b0));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
        tbl.push_back(b(1'b1, 1'b0, 8'd0));
        tbl.push_back(b(1'b0, 1'b0, 8'd0));
        tbl.push_back(b(1'b0, 1'b0, 8'd0));
        tbl.push_back(b(1'b1, 1'b1, 8'd1));
        tbl.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0));
        tbl.push_back(b(1'b0, 1'b0, 8'd1));
        tbl.push_back(b(1'b0, 1'b0, 8'd1));
        tbl.push_back(b(1'b1, 1'b1, 8'd2));
        tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0));
        tbl.push_back(c(4'b1001, 3'd4, 1'b0, 8'd0, 8'd2, 1'b0));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
        tbl.push_back(b(1'b1, 1'b0, 8'd0));
        tbl.push_back(b(1'b0, 1'b0, 8'd0));
        tbl.push_back(b(1'b0, 1'b0, 8'd0));
        tbl.push_back(b(1'b1, 1'b1, 8'd1));
        tbl.push_back(b(1'b0, 1'b0, 8'd1));
        tbl.push_back(b(1'b0, 1'b0, 8'd1));
        tbl.push_back(b(1'b1, 1'b0, 8'd1));
        tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0));
        tbl.push_back(c(4'b1001, 3'd4, 1'b1, 8'd2, 8'd1, 1'b0));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
        tbl.push_back(b(1'b1, 1'b0, 8'd0));
        tbl.push_back(b(1'b0, 1'b0, 8'd0));
        tbl.push_back(b(1'b0, 1'b0, 8'd0));
        tbl.push_back(b(1'b1, 1'b1, 8'd1));
        tbl.push_back(b(1'b0, 1'b0, 8'd1));
        tbl.push_back(b(1'b0, 1'b0, 8'd1));
        tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            drive(tbl[i].cv, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].lim,
                  tbl[i].st, tbl[i].ab, tbl[i].bv, tbl[i].bi);
            step();
            chk($sformatf("tbl[%0d].det_pulse", i), det_pulse, tbl[i].det);
            chk($sformatf("tbl[%0d].match_cnt", i), match_cnt, tbl[i].cnt);
            chk($sformatf("tbl[%0d].busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl[%0d].done", i), done, tbl[i].done);
        end
        idle_inputs();

        // config offered during RUN is refused; start+abort together aborts
        do_cfg(4'b1001, 3'd4, 1'b1, 8'd0);
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b0);
        drive(1'b1, 4'b0110, 3'd4, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("run.cfg_ready", cfg_ready, 0);
        step();
        idle_inputs();
        send_bit(1'b1);
        chk("run.old_cfg_det", det_pulse, 1);
        chk("run.old_cfg_cnt", match_cnt, 1);
        start = 1'b1; abort = 1'b1; step(); idle_inputs();
        chk("stab.busy", busy, 0);
        chk("stab.done", done, 0);
        chk("stab.match_cnt", match_cnt, 1);
        chk("stab.cfg_ready", cfg_ready, 1);

        // reset mid-session, then a session on the reset config (pattern 00, len 2)
        do_cfg(4'b1001, 3'd4, 1'b1, 8'd0);
        pulse_start();
        for (int i = 3; i >= 0; i--) send_bit(bits_a[i]);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("mrst.det_pulse", det_pulse, 0);
        chk("mrst.match_cnt", match_cnt, 0);
        chk("mrst.busy", busy, 0);
        chk("mrst.done", done, 0);
        chk("mrst.timed_out", timed_out, 0);
        pulse_start();
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits_a[i]);
            chk($sformatf("mrst.bit%0d_det", 4 - i), det_pulse, (i == 1) ? 1 : 0);
        end
        chk("mrst.final_cnt", match_cnt, 1);
        pulse_abort();

`ifdef SEQ_DET_TIMEOUT_EN
        do_cfg(4'b1001, 3'd4, 1'b1, 8'd0);
        pulse_start();
        for (int i = 1; i <= TMO; i++) begin
            send_bit(1'b0);
            chk($sformatf("tmo.bit%0d_det", i), det_pulse, 0);
            chk($sformatf("tmo.bit%0d_done", i), done, (i == TMO) ? 1 : 0);
            chk($sformatf("tmo.bit%0d_timed", i), timed_out, (i == TMO) ? 1 : 0);
        end
        pulse_abort();
        chk("tmo.abort_clear", timed_out, 0);
`endif

        // randomized cycles against the reference model
        idle_inputs();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            logic cv, st, ab;
            st = ($urandom_range(0, 11) == 0);
            ab = ($urandom_range(0, 29) == 0);
            cv = !st && ($urandom_range(0, 7) == 0);
            model_cycle(cv, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), st, ab,
                        ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
